// File: rtl/memory_burst_control_if.sv
// memory_burst_control_if: controller/RAM-side bus of the burst sequencer
//   master: drives load_memory, base_addr, process, cancel; observes the RAM/status outputs
//   slave : the sequencer side, receiving the requests and driving address, strobes and status
interface memory_burst_control_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int BURST_LEN  = 4
);
  logic                               load_memory;
  logic [ADDR_WIDTH-1:0]              base_addr;
  logic [2:0]                         process;
  logic                               cancel;
  logic [ADDR_WIDTH-1:0]              address;
  logic                               write_enable;
  logic                               access_type;
  logic                               read_valid;
  logic                               write_ack;
  logic [$clog2(BURST_LEN+1)-1:0]     word_index;
  logic                               done;
  modport master (
    output load_memory, base_addr, process, cancel,
    input  address, write_enable, access_type, read_valid, write_ack, word_index, done
  );
  modport slave (
    input  load_memory, base_addr, process, cancel,
    output address, write_enable, access_type, read_valid, write_ack, word_index, done
  );
endinterface

// File: rtl/memory_burst_control.sv
// memory_burst_control: burst read, park until released, burst write back over the same range
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : load_memory/base_addr start a burst, process/cancel resolve HOLD,
//                  address/write_enable/access_type/read_valid/write_ack/word_index/done drive the RAM and controller
module memory_burst_control #(
  parameter int         ADDR_WIDTH = 5,
  parameter int         BURST_LEN  = 4,
  parameter int         READ_WAIT  = 7,
  parameter int         WRITE_WAIT = 7,
  parameter logic [2:0] PROCESS_GO = 3'b100
) (
  input logic                    clock,
  input logic                    reset,
  memory_burst_control_if.slave  bus
);
  localparam int WIW  = $clog2(BURST_LEN + 1);
  localparam int MAXW = READ_WAIT > WRITE_WAIT ? READ_WAIT : WRITE_WAIT;
  localparam int WTW  = $clog2(MAXW + 1);
  typedef enum logic [1:0] {IDLE, READ, HOLD, WRITE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d, address_q, address_d;
  logic [WIW-1:0]        word_q, word_d, word_index_q, word_index_d;
  logic [WTW-1:0]        wait_q, wait_d;
  logic                  last_wait, last_word, active;
  logic                  write_enable_q, write_enable_d, read_valid_q, read_valid_d;
  logic                  write_ack_q, write_ack_d, done_q, done_d;
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    addr_d    = addr_q;
    word_d    = word_q;
    wait_d    = wait_q;
    last_wait = wait_q == (state_q == WRITE ? WTW'(WRITE_WAIT - 1) : WTW'(READ_WAIT - 1));
    last_word = word_q == WIW'(BURST_LEN - 1);
    case (state_q)
      IDLE: if (bus.load_memory) begin
        state_d = READ;
        base_d  = bus.base_addr;
        addr_d  = bus.base_addr;
        word_d  = '0;
        wait_d  = '0;
      end
      HOLD: state_d = bus.cancel ? IDLE : bus.process == PROCESS_GO ? WRITE : HOLD;
      default: if (last_wait) begin
        wait_d  = '0;
        state_d = last_word ? (state_q == READ ? HOLD : IDLE) : state_q;
        addr_d  = last_word ? base_q : addr_q + ADDR_WIDTH'(1);
        word_d  = last_word ? '0 : word_q + WIW'(1);
      end else begin
        wait_d = wait_q + WTW'(1);
      end
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    active         = state_d == READ || state_d == WRITE;
    address_d      = active ? addr_d : '0;
    word_index_d   = active ? word_d : '0;
    write_enable_d = state_d == WRITE;
    read_valid_d   = state_d == READ && wait_d == WTW'(READ_WAIT - 1);
    write_ack_d    = state_d == WRITE && wait_d == WTW'(WRITE_WAIT - 1);
    done_d         = state_d == IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      addr_q         <= '0;
      word_q         <= '0;
      wait_q         <= '0;
      address_q      <= '0;
      word_index_q   <= '0;
      write_enable_q <= 1'b0;
      read_valid_q   <= 1'b0;
      write_ack_q    <= 1'b0;
      done_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      addr_q         <= addr_d;
      word_q         <= word_d;
      wait_q         <= wait_d;
      address_q      <= address_d;
      word_index_q   <= word_index_d;
      write_enable_q <= write_enable_d;
      read_valid_q   <= read_valid_d;
      write_ack_q    <= write_ack_d;
      done_q         <= done_d;
    end
  end
  assign bus.address      = address_q;
  assign bus.word_index   = word_index_q;
  assign bus.write_enable = write_enable_q;
  assign bus.access_type  = write_enable_q;
  assign bus.read_valid   = read_valid_q;
  assign bus.write_ack    = write_ack_q;
  assign bus.done         = done_q;
endmodule
